// File: rtl/map_collision_writer.sv
// Map collision lookup and sprite writer.
// Looks up the tile under pacman's requested position, keeps the pill
// immunity countdown, and rewrites the map RAM when pacman or a ghost moves.
module map_collision_writer #(
  parameter int          MAP_W     = 40,
  parameter int          MAP_H     = 30,
  parameter logic [32:0] PILL_TIME = 33'd1_500_000_000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        colli_clr,
  input  logic [5:0]  next_pacman_x,
  input  logic [4:0]  next_pacman_y,
  input  logic [5:0]  curr_pacman_x,
  input  logic [4:0]  curr_pacman_y,
  input  logic [5:0]  curr_ghost1_x,
  input  logic [4:0]  curr_ghost1_y,
  input  logic [5:0]  next_ghost1_x,
  input  logic [4:0]  next_ghost1_y,
  input  logic [5:0]  curr_ghost2_x,
  input  logic [4:0]  curr_ghost2_y,
  input  logic [5:0]  next_ghost2_x,
  input  logic [4:0]  next_ghost2_y,
  output logic [10:0] rdaddr,
  input  logic [3:0]  rddata,
  output logic [10:0] wraddr,
  output logic [3:0]  wrdata,
  output logic        wren,
  output logic [3:0]  collision_type,
  output logic [32:0] pill_count,
  output logic        pac_done,
  output logic        ghost_done
);

  typedef enum logic [3:0] {
    IDLE,
    P_CLR,
    P_SET,
    P_DONE,
    G1_CLR,
    G1_SET,
    G2_CLR,
    G2_SET,
    G_DONE
  } state_t;

  localparam logic [3:0] TILE_EMPTY  = 4'd0;
  localparam logic [3:0] TILE_WALL   = 4'd1;
  localparam logic [3:0] TILE_DOT    = 4'd2;
  localparam logic [3:0] TILE_PILL   = 4'd3;
  localparam logic [3:0] TILE_PACMAN = 4'd4;
  localparam logic [3:0] TILE_GHOST  = 4'd5;

  localparam logic [3:0] COLLI_NONE  = 4'b0000;
  localparam logic [3:0] COLLI_WALL  = 4'b0001;
  localparam logic [3:0] COLLI_DOT   = 4'b0010;
  localparam logic [3:0] COLLI_PILL  = 4'b0100;
  localparam logic [3:0] COLLI_GHOST = 4'b1000;

  function automatic logic [10:0] tileAddr(input logic [5:0] x, input logic [4:0] y);
    tileAddr = 11'(y) * 11'(MAP_W) + 11'(x);
  endfunction

  function automatic logic inMap(input logic [5:0] x, input logic [4:0] y);
    inMap = (int'(x) < MAP_W) && (int'(y) < MAP_H);
  endfunction

  // Collision path registers
  logic        outOfRange_q;
  logic [3:0]  collision_q, collision_d;
  logic [32:0] pill_q, pill_d;
  logic [32:0] pillBase;
  logic [33:0] pillSum;
  logic [3:0]  tileDecode;

  // Writer FSM registers
  state_t      state_q, state_d;
  logic [5:0]  pacCurX_q, pacCurX_d, pacNxtX_q, pacNxtX_d;
  logic [4:0]  pacCurY_q, pacCurY_d, pacNxtY_q, pacNxtY_d;
  logic [5:0]  g1CurX_q, g1CurX_d, g1NxtX_q, g1NxtX_d;
  logic [4:0]  g1CurY_q, g1CurY_d, g1NxtY_q, g1NxtY_d;
  logic [5:0]  g2CurX_q, g2CurX_d, g2NxtX_q, g2NxtX_d;
  logic [4:0]  g2CurY_q, g2CurY_d, g2NxtY_q, g2NxtY_d;
  logic [10:0] wrAddr_q, wrAddr_d;
  logic [3:0]  wrData_q, wrData_d;
  logic        wrEn_d;
  logic        pacDone_d, ghostDone_d;

  logic        pacMoveReq, g1MoveReq, g2MoveReq;
  logic        g2MoveLatched;

  assign rdaddr = tileAddr(next_pacman_x, next_pacman_y);

  assign pacMoveReq    = (curr_pacman_x != next_pacman_x) || (curr_pacman_y != next_pacman_y);
  assign g1MoveReq     = (curr_ghost1_x != next_ghost1_x) || (curr_ghost1_y != next_ghost1_y);
  assign g2MoveReq     = (curr_ghost2_x != next_ghost2_x) || (curr_ghost2_y != next_ghost2_y);
  assign g2MoveLatched = (g2CurX_q != g2NxtX_q) || (g2CurY_q != g2NxtY_q);

  // Decode the RAM tile; the range flag is delayed so it lines up with rddata
  always_comb begin
    tileDecode = COLLI_NONE;
    case (rddata)
      TILE_WALL:  tileDecode = COLLI_WALL;
      TILE_DOT:   tileDecode = COLLI_DOT;
      TILE_PILL:  tileDecode = COLLI_PILL;
      TILE_GHOST: tileDecode = COLLI_GHOST;
      TILE_EMPTY, TILE_PACMAN: tileDecode = COLLI_NONE;
      default:    tileDecode = COLLI_NONE;
    endcase

    collision_d = outOfRange_q ? COLLI_WALL : tileDecode;
    if (colli_clr) begin
      collision_d = COLLI_NONE;
    end
  end

  // Pill countdown: every cycle ticks down, and a fresh pill adds a full period on top
  always_comb begin
    pillBase = (pill_q != 33'd0) ? (pill_q - 33'd1) : 33'd0;
    pillSum  = {1'b0, pillBase} + {1'b0, PILL_TIME};
    pill_d   = pillBase;
    if ((collision_d == COLLI_PILL) && (collision_q != COLLI_PILL)) begin
      pill_d = pillSum[33] ? {33{1'b1}} : pillSum[32:0];
    end
  end

  // Collision and pill state registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      outOfRange_q <= 1'b0;
      collision_q  <= COLLI_NONE;
      pill_q       <= 33'd0;
    end else begin
      outOfRange_q <= !inMap(next_pacman_x, next_pacman_y);
      collision_q  <= collision_d;
      pill_q       <= pill_d;
    end
  end

  assign collision_type = collision_q;
  assign pill_count     = pill_q;

  // Writer FSM: sequencing, coordinate latching and RAM write outputs
  always_comb begin
    state_d     = state_q;
    pacCurX_d   = pacCurX_q;
    pacCurY_d   = pacCurY_q;
    pacNxtX_d   = pacNxtX_q;
    pacNxtY_d   = pacNxtY_q;
    g1CurX_d    = g1CurX_q;
    g1CurY_d    = g1CurY_q;
    g1NxtX_d    = g1NxtX_q;
    g1NxtY_d    = g1NxtY_q;
    g2CurX_d    = g2CurX_q;
    g2CurY_d    = g2CurY_q;
    g2NxtX_d    = g2NxtX_q;
    g2NxtY_d    = g2NxtY_q;
    wrAddr_d    = wrAddr_q;
    wrData_d    = wrData_q;
    wrEn_d      = 1'b0;
    pacDone_d   = 1'b0;
    ghostDone_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pacMoveReq) begin
          state_d   = P_CLR;
          pacCurX_d = curr_pacman_x;
          pacCurY_d = curr_pacman_y;
          pacNxtX_d = next_pacman_x;
          pacNxtY_d = next_pacman_y;
        end else if (g1MoveReq || g2MoveReq) begin
          state_d  = g1MoveReq ? G1_CLR : G2_CLR;
          g1CurX_d = curr_ghost1_x;
          g1CurY_d = curr_ghost1_y;
          g1NxtX_d = next_ghost1_x;
          g1NxtY_d = next_ghost1_y;
          g2CurX_d = curr_ghost2_x;
          g2CurY_d = curr_ghost2_y;
          g2NxtX_d = next_ghost2_x;
          g2NxtY_d = next_ghost2_y;
        end
      end
      P_CLR: begin
        wrEn_d   = inMap(pacCurX_q, pacCurY_q);
        wrAddr_d = tileAddr(pacCurX_q, pacCurY_q);
        wrData_d = TILE_EMPTY;
        state_d  = P_SET;
      end
      P_SET: begin
        wrEn_d   = inMap(pacNxtX_q, pacNxtY_q);
        wrAddr_d = tileAddr(pacNxtX_q, pacNxtY_q);
        wrData_d = TILE_PACMAN;
        state_d  = P_DONE;
      end
      P_DONE: begin
        pacDone_d = 1'b1;
        state_d   = IDLE;
      end
      G1_CLR: begin
        wrEn_d   = inMap(g1CurX_q, g1CurY_q);
        wrAddr_d = tileAddr(g1CurX_q, g1CurY_q);
        wrData_d = TILE_EMPTY;
        state_d  = G1_SET;
      end
      G1_SET: begin
        wrEn_d   = inMap(g1NxtX_q, g1NxtY_q);
        wrAddr_d = tileAddr(g1NxtX_q, g1NxtY_q);
        wrData_d = TILE_GHOST;
        state_d  = g2MoveLatched ? G2_CLR : G_DONE;
      end
      G2_CLR: begin
        wrEn_d   = inMap(g2CurX_q, g2CurY_q);
        wrAddr_d = tileAddr(g2CurX_q, g2CurY_q);
        wrData_d = TILE_EMPTY;
        state_d  = G2_SET;
      end
      G2_SET: begin
        wrEn_d   = inMap(g2NxtX_q, g2NxtY_q);
        wrAddr_d = tileAddr(g2NxtX_q, g2NxtY_q);
        wrData_d = TILE_GHOST;
        state_d  = G_DONE;
      end
      G_DONE: begin
        ghostDone_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Writer FSM state, latched coordinates and held write address/data
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      pacCurX_q <= '0;
      pacCurY_q <= '0;
      pacNxtX_q <= '0;
      pacNxtY_q <= '0;
      g1CurX_q  <= '0;
      g1CurY_q  <= '0;
      g1NxtX_q  <= '0;
      g1NxtY_q  <= '0;
      g2CurX_q  <= '0;
      g2CurY_q  <= '0;
      g2NxtX_q  <= '0;
      g2NxtY_q  <= '0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
    end else begin
      state_q   <= state_d;
      pacCurX_q <= pacCurX_d;
      pacCurY_q <= pacCurY_d;
      pacNxtX_q <= pacNxtX_d;
      pacNxtY_q <= pacNxtY_d;
      g1CurX_q  <= g1CurX_d;
      g1CurY_q  <= g1CurY_d;
      g1NxtX_q  <= g1NxtX_d;
      g1NxtY_q  <= g1NxtY_d;
      g2CurX_q  <= g2CurX_d;
      g2CurY_q  <= g2CurY_d;
      g2NxtX_q  <= g2NxtX_d;
      g2NxtY_q  <= g2NxtY_d;
      wrAddr_q  <= wrAddr_d;
      wrData_q  <= wrData_d;
    end
  end

  assign wren       = wrEn_d;
  assign wraddr     = wrAddr_d;
  assign wrdata     = wrData_d;
  assign pac_done   = pacDone_d;
  assign ghost_done = ghostDone_d;

endmodule

// File: tb/tb_map_collision_writer.sv
// Directed testbench for map_collision_writer with a small map RAM model.
module tb_map_collision_writer;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        colli_clr;
  logic [5:0]  next_pacman_x, curr_pacman_x;
  logic [4:0]  next_pacman_y, curr_pacman_y;
  logic [5:0]  curr_ghost1_x, next_ghost1_x, curr_ghost2_x, next_ghost2_x;
  logic [4:0]  curr_ghost1_y, next_ghost1_y, curr_ghost2_y, next_ghost2_y;
  logic [10:0] rdaddr, wraddr;
  logic [3:0]  rddata, wrdata, collision_type;
  logic        wren, pac_done, ghost_done;
  logic [32:0] pill_count;

  logic [3:0]  mem [0:1199];
  logic [3:0]  rdTmp;
  int          vectors = 0;
  int          miscompares = 0;

  map_collision_writer dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .colli_clr     (colli_clr),
    .next_pacman_x (next_pacman_x),
    .next_pacman_y (next_pacman_y),
    .curr_pacman_x (curr_pacman_x),
    .curr_pacman_y (curr_pacman_y),
    .curr_ghost1_x (curr_ghost1_x),
    .curr_ghost1_y (curr_ghost1_y),
    .next_ghost1_x (next_ghost1_x),
    .next_ghost1_y (next_ghost1_y),
    .curr_ghost2_x (curr_ghost2_x),
    .curr_ghost2_y (curr_ghost2_y),
    .next_ghost2_x (next_ghost2_x),
    .next_ghost2_y (next_ghost2_y),
    .rdaddr        (rdaddr),
    .rddata        (rddata),
    .wraddr        (wraddr),
    .wrdata        (wrdata),
    .wren          (wren),
    .collision_type(collision_type),
    .pill_count    (pill_count),
    .pac_done      (pac_done),
    .ghost_done    (ghost_done)
  );

  // 50 MHz-style free-running clock
  always #5 CLOCK_50 = ~CLOCK_50;

  // Map RAM model: registered read, write on the same edge
  initial begin
    for (int i = 0; i < 1200; i++) mem[i] = 4'd0;
    mem[819] = 4'd1;
    mem[100] = 4'd2;
    mem[101] = 4'd3;
    mem[102] = 4'd6;
    mem[103] = 4'd5;
    rddata = 4'd0;
    forever begin
      @(posedge CLOCK_50);
      rdTmp = (rdaddr < 11'd1200) ? mem[rdaddr] : 4'd0;
      if (wren && (wraddr < 11'd1200)) mem[wraddr] = wrdata;
      rddata <= rdTmp;
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic applyStimulus(input int cx, input int cy, input int nx, input int ny);
    curr_pacman_x = 6'(cx);
    curr_pacman_y = 5'(cy);
    next_pacman_x = 6'(nx);
    next_pacman_y = 5'(ny);
  endtask

  task automatic setGhost1(input int cx, input int cy, input int nx, input int ny);
    curr_ghost1_x = 6'(cx);
    curr_ghost1_y = 5'(cy);
    next_ghost1_x = 6'(nx);
    next_ghost1_y = 5'(ny);
  endtask

  task automatic setGhost2(input int cx, input int cy, input int nx, input int ny);
    curr_ghost2_x = 6'(cx);
    curr_ghost2_y = 5'(cy);
    next_ghost2_x = 6'(nx);
    next_ghost2_y = 5'(ny);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkWrite(input string tag, input logic en, input int addr, input int data);
    checkOutput({tag, "_wren"}, 64'(wren), 64'(en));
    checkOutput({tag, "_wraddr"}, 64'(wraddr), 64'(addr));
    checkOutput({tag, "_wrdata"}, 64'(wrdata), 64'(data));
  endtask

  task automatic checkDone(input string tag, input logic pd, input logic gd);
    checkOutput({tag, "_pac_done"}, 64'(pac_done), 64'(pd));
    checkOutput({tag, "_ghost_done"}, 64'(ghost_done), 64'(gd));
  endtask

  // Directed sequence
  initial begin
    reset = 1'b1;
    colli_clr = 1'b0;
    applyStimulus(0, 0, 0, 0);
    setGhost1(16, 13, 16, 13);
    setGhost2(5, 5, 5, 5);
    tick();
    tick();

    checkOutput("rst_collision", 64'(collision_type), 64'd0);
    checkOutput("rst_pill", 64'(pill_count), 64'd0);
    checkWrite("rst", 1'b0, 0, 0);
    checkDone("rst", 1'b0, 1'b0);

    reset = 1'b0;
    applyStimulus(19, 20, 19, 20);
    #1;
    checkOutput("rdaddr_19_20", 64'(rdaddr), 64'd819);
    tick();
    tick();
    checkOutput("colli_wall", 64'(collision_type), 64'b0001);
    checkOutput("pill_idle", 64'(pill_count), 64'd0);

    applyStimulus(20, 2, 20, 2);
    tick();
    tick();
    checkOutput("colli_dot", 64'(collision_type), 64'b0010);

    applyStimulus(21, 2, 21, 2);
    tick();
    tick();
    checkOutput("colli_pill", 64'(collision_type), 64'b0100);
    checkOutput("pill_first", 64'(pill_count), 64'd1_500_000_000);
    tick();
    checkOutput("pill_dec1", 64'(pill_count), 64'd1_499_999_999);

    applyStimulus(20, 2, 20, 2);
    repeat (97) tick();
    applyStimulus(21, 2, 21, 2);
    tick();
    tick();
    checkOutput("pill_second_colli", 64'(collision_type), 64'b0100);
    checkOutput("pill_second", 64'(pill_count), 64'd2_999_999_900);
    tick();
    checkOutput("pill_hold_no_readd", 64'(pill_count), 64'd2_999_999_899);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(20, 2, 20, 2);
      tick();
      applyStimulus(21, 2, 21, 2);
      tick();
    end
    tick();
    checkOutput("pill_sat_colli", 64'(collision_type), 64'b0100);
    checkOutput("pill_saturated", 64'(pill_count), 64'h1_FFFF_FFFF);
    tick();
    checkOutput("pill_sat_dec", 64'(pill_count), 64'h1_FFFF_FFFE);

    applyStimulus(22, 2, 22, 2);
    tick();
    tick();
    checkOutput("colli_code6_none", 64'(collision_type), 64'b0000);
    applyStimulus(23, 2, 23, 2);
    tick();
    tick();
    checkOutput("colli_ghost", 64'(collision_type), 64'b1000);

    applyStimulus(19, 20, 19, 20);
    tick();
    tick();
    checkOutput("colli_wall_again", 64'(collision_type), 64'b0001);
    colli_clr = 1'b1;
    tick();
    checkOutput("colli_clr", 64'(collision_type), 64'b0000);
    colli_clr = 1'b0;
    tick();
    checkOutput("colli_after_clr", 64'(collision_type), 64'b0001);

    applyStimulus(20, 2, 20, 2);
    tick();
    tick();
    checkOutput("colli_dot_pre_oor", 64'(collision_type), 64'b0010);
    applyStimulus(45, 20, 45, 20);
    tick();
    tick();
    checkOutput("colli_oor_x45", 64'(collision_type), 64'b0001);
    applyStimulus(20, 2, 20, 2);
    tick();
    tick();
    applyStimulus(10, 30, 10, 30);
    tick();
    tick();
    checkOutput("colli_oor_y30", 64'(collision_type), 64'b0001);

    // Pacman move with a mid-sequence input change that must be ignored
    applyStimulus(20, 20, 19, 20);
    tick();
    checkWrite("pac_clr", 1'b1, 820, 0);
    checkDone("pac_clr", 1'b0, 1'b0);
    applyStimulus(20, 20, 18, 20);
    tick();
    checkWrite("pac_set", 1'b1, 819, 4);
    tick();
    checkWrite("pac_done_hold", 1'b0, 819, 4);
    checkDone("pac_done", 1'b1, 1'b0);
    applyStimulus(19, 20, 19, 20);
    tick();
    checkWrite("pac_idle", 1'b0, 819, 4);
    checkDone("pac_idle", 1'b0, 1'b0);
    tick();
    checkOutput("pac_tile_written", 64'(collision_type), 64'b0000);
    checkOutput("pac_idle2_wren", 64'(wren), 64'd0);

    // Ghost1 only
    setGhost1(16, 13, 17, 13);
    tick();
    checkWrite("g1_clr", 1'b1, 536, 0);
    tick();
    checkWrite("g1_set", 1'b1, 537, 5);
    tick();
    checkOutput("g1_done_wren", 64'(wren), 64'd0);
    checkDone("g1_done", 1'b0, 1'b1);
    setGhost1(17, 13, 17, 13);
    tick();
    checkOutput("g1_idle_wren", 64'(wren), 64'd0);
    checkDone("g1_idle", 1'b0, 1'b0);

    // Ghost2 only
    setGhost2(5, 5, 6, 5);
    tick();
    checkWrite("g2_clr", 1'b1, 205, 0);
    tick();
    checkWrite("g2_set", 1'b1, 206, 5);
    tick();
    checkDone("g2_done", 1'b0, 1'b1);
    setGhost2(6, 5, 6, 5);
    tick();
    checkDone("g2_idle", 1'b0, 1'b0);

    // Pacman and ghost1 together: pacman first
    applyStimulus(19, 20, 20, 20);
    setGhost1(17, 13, 16, 13);
    tick();
    checkWrite("prio_p_clr", 1'b1, 819, 0);
    tick();
    checkWrite("prio_p_set", 1'b1, 820, 4);
    tick();
    checkDone("prio_p_done", 1'b1, 1'b0);
    applyStimulus(20, 20, 20, 20);
    tick();
    checkOutput("prio_idle_wren", 64'(wren), 64'd0);
    checkDone("prio_idle", 1'b0, 1'b0);
    tick();
    checkWrite("prio_g1_clr", 1'b1, 537, 0);
    tick();
    checkWrite("prio_g1_set", 1'b1, 536, 5);
    tick();
    checkDone("prio_g_done", 1'b0, 1'b1);
    setGhost1(16, 13, 16, 13);
    tick();

    // Out-of-range target suppresses the write but still completes
    applyStimulus(20, 20, 45, 20);
    tick();
    checkWrite("oor_clr", 1'b1, 820, 0);
    tick();
    checkWrite("oor_set", 1'b0, 845, 4);
    tick();
    checkDone("oor_done", 1'b1, 1'b0);
    applyStimulus(20, 20, 20, 20);
    tick();

    // Reset during P_SET
    applyStimulus(20, 20, 19, 20);
    tick();
    tick();
    checkWrite("rstmid_pset", 1'b1, 819, 4);
    reset = 1'b1;
    tick();
    checkWrite("rstmid", 1'b0, 0, 0);
    checkDone("rstmid", 1'b0, 1'b0);
    checkOutput("rstmid_collision", 64'(collision_type), 64'd0);
    checkOutput("rstmid_pill", 64'(pill_count), 64'd0);
    reset = 1'b0;
    applyStimulus(19, 20, 19, 20);
    tick();
    checkDone("rstmid_after1", 1'b0, 1'b0);
    checkOutput("rstmid_after1_wren", 64'(wren), 64'd0);
    tick();
    checkDone("rstmid_after2", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/map_collision_writer.md
MAP_COLLISION_WRITER -- requirements
Module: map_collision_writer

Interface
REQ-001 Parameters: MAP_W 40, tile columns; MAP_H 30, tile rows; PILL_TIME 1_500_000_000, cycles added per pill (30 s at 50 MHz).
REQ-002 CLOCK_50  in  1  sole clock, all state on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 colli_clr  in  1  synchronous clear of collision_type.
REQ-005 next_pacman_x / next_pacman_y  in  6 / 5  requested pacman tile (collision lookup and write target).
REQ-006 curr_pacman_x / curr_pacman_y  in  6 / 5  pacman's current tile.
REQ-007 curr_ghost1_x, curr_ghost1_y, next_ghost1_x, next_ghost1_y, and the same four for ghost2  in  6/5/6/5  ghost current and next tiles.
REQ-008 rdaddr  out  11  map RAM read address, combinational.
REQ-009 rddata  in  4  map RAM read data, valid one cycle after rdaddr.
REQ-010 wraddr  out  11  map RAM write address.
REQ-011 wrdata  out  4  map RAM write data.
REQ-012 wren  out  1  map RAM write enable.
REQ-013 collision_type  out  4  one-hot: 0001 wall, 0010 dot, 0100 pill, 1000 ghost, 0000 none.
REQ-014 pill_count  out  33  remaining immunity cycles.
REQ-015 pac_done / ghost_done  out  1 / 1  single-cycle completion pulses.

Function
REQ-016 Tile codes: 0 empty, 1 wall, 2 dot, 3 pill, 4 pacman, 5 ghost; codes 6-15 decode as none.
REQ-017 Address = y*MAP_W + x, 11 bits unsigned.
REQ-018 rdaddr SHALL follow next_pacman_x/y combinationally.
REQ-019 Collision latency: collision_type reflects the tile of the coordinate presented two cycles earlier (RAM cycle plus one register).
REQ-020 Out-of-range coordinate (x>=MAP_W or y>=MAP_H) SHALL register collision_type 0001.
REQ-021 colli_clr=1 SHALL force collision_type to 0000 on the next edge, overriding the decode.
REQ-022 pill_count: adds PILL_TIME on the edge where collision_type becomes 0100 from any other value, saturating at 2^33-1.
REQ-023 pill_count: otherwise decrements by 1 per cycle while nonzero and holds at 0.
REQ-024 Writer FSM states: IDLE, P_CLR, P_SET, P_DONE, G1_CLR, G1_SET, G2_CLR, G2_SET, G_DONE.
REQ-025 IDLE: pacman curr!=next SHALL go to P_CLR and latch all four pacman coordinates; pacman has priority over ghosts.
REQ-026 IDLE: otherwise, if either ghost's curr!=next, SHALL go to the first differing ghost's CLR state and latch the ghost coordinates.
REQ-027 P_CLR: wren=1, wraddr=curr addr, wrdata=0. P_SET: wren=1, wraddr=next addr, wrdata=4. P_DONE: pac_done=1 for one cycle, then IDLE.
REQ-028 G1_CLR: wren=1, wrdata=0 at the ghost1 curr address. G1_SET: wren=1, wrdata=5 at the ghost1 next address. G2_CLR and G2_SET do the same for ghost2.
REQ-029 A ghost whose curr==next at latch time SHALL have its CLR/SET states skipped. G_DONE: ghost_done=1 for one cycle, then IDLE.
REQ-030 Input changes during a sequence SHALL be ignored (latched values used).
REQ-031 Out-of-range latched coordinates SHALL suppress wren in that state; the sequence still completes and the done pulse still occurs.
REQ-032 wren=0, wraddr and wrdata hold their last values outside write states; pac_done and ghost_done are never high simultaneously.
REQ-033 pac_done fires exactly 3 cycles after the IDLE cycle that detected the move.

Reset
REQ-034 reset SHALL take priority over all other inputs, including mid-sequence, returning the FSM to IDLE with no done pulse.
REQ-035 Reset values: collision_type=0000, pill_count=0, wren=0, wraddr=0, wrdata=0, pac_done=0, ghost_done=0, latched coordinates=0.

Verification
REQ-036 Collision: next=(19,20) with the RAM holding 1 there -> collision_type=0001 two cycles later; a dot tile -> 0010.
REQ-037 Pacman move: curr=(20,20), next=(19,20) with ghosts static -> wren writes 0 at addr 820, then 4 at addr 819, then pac_done pulse; wren low afterwards once curr is updated.
REQ-038 Pill: pill tile presented -> pill_count=1_500_000_000 on that edge, then decreasing by 1 per cycle; a second pill 100 cycles later -> 2_999_999_900.
REQ-039 Ghosts: ghost1 (16,13)->(17,13), ghost2 static -> writes 0 at addr 536, 5 at addr 537, then ghost_done; no ghost2 writes.
REQ-040 Priority/reset: pacman and ghost1 moves requested together -> full pacman sequence first, then ghost; reset asserted in P_SET -> next cycle IDLE, all outputs at reset values.
REQ-041 colli_clr asserted with a wall tile present -> collision_type=0000; out-of-range next x=45 -> collision_type=0001.
